// File: rtl/input_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : input_debounce_bank
// Brief    : Per-bit 2-flop synchroniser and counter debouncer with one-cycle
//            rise/fall strobes, feeding the gate microtile inputs.
// Revision : 1.0 - initial release
// ============================================================================
module input_debounce_bank #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > (2 ** CNT_W))) begin : g_cfg_err
            $error("input_debounce_bank: DEBOUNCE_CYCLES out of range 1..2**CNT_W");
        end
    endgenerate

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_any;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_clean_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic             w_any_nxt;

    // The counter tracks consecutive enabled edges on which sync2 disagrees
    // with the clean level; clean follows once that run reaches DEBOUNCE_CYCLES.
    always_comb begin
        w_clean_nxt = r_clean;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (ena) begin
                if (r_sync2[i] == r_clean[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == c_last) begin
                    w_clean_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i]   = '0;
                    w_rise_nxt[i]  = r_sync2[i];
                    w_fall_nxt[i]  = ~r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
        w_any_nxt = |(w_rise_nxt | w_fall_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_clean <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_any   <= w_any_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign clean_out  = r_clean;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign any_change = r_any;

endmodule
`default_nettype wire
